// File: rtl/tpu_act_pkg.sv
// Shared activation definitions: mode encoding, per-lane result select and
// the fixed-point round/saturate helper also used by forward activation blocks.
package tpu_act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU     = 2'd0,
        ACT_LEAKY    = 2'd1,
        ACT_IDENTITY = 2'd2,
        ACT_RSVD     = 2'd3
    } act_mode_e;

    // Per-lane result select after mask and mode decode
    typedef enum logic [1:0] {
        SEL_ZERO  = 2'd0,
        SEL_PASS  = 2'd1,
        SEL_RELU  = 2'd2,
        SEL_LEAKY = 2'd3
    } lane_sel_e;

    // Widest product the helper handles; data widths up to 32 bits
    localparam int unsigned MAX_PROD_W = 64;

    // Collapse mode and lane mask into one select
    function automatic lane_sel_e decode_sel(input act_mode_e mode, input logic mask);
        lane_sel_e sel;
        sel = SEL_ZERO;
        if (mask) begin
            case (mode)
                ACT_RELU:     sel = SEL_RELU;
                ACT_LEAKY:    sel = SEL_LEAKY;
                ACT_IDENTITY: sel = SEL_PASS;
                default:      sel = SEL_ZERO;
            endcase
        end
        return sel;
    endfunction

    // Round half up (toward +inf) by frac bits, then clamp to a signed width-bit range
    function automatic logic signed [MAX_PROD_W-1:0] round_sat(
        input logic signed [MAX_PROD_W-1:0] prod,
        input int unsigned                  width,
        input int unsigned                  frac
    );
        logic signed [MAX_PROD_W-1:0] rnd;
        logic signed [MAX_PROD_W-1:0] hi;
        logic signed [MAX_PROD_W-1:0] lo;
        rnd = (prod + (64'sd1 <<< (frac - 1))) >>> frac;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (width - 1));
        if (rnd > hi) begin
            rnd = hi;
        end else if (rnd < lo) begin
            rnd = lo;
        end
        return rnd;
    endfunction

endpackage

// File: rtl/activation_derivative_lane.sv
// One lane of the activation-derivative datapath.
// S1 captures sign of h, pass value, full product and decoded select;
// S2 captures the rounded/saturated/selected result.
// Ports: clk, rst (async, active-high); s1_en/s2_en stage advance enables;
// s1_load/s2_load say whether the advancing stage receives a valid beat
// (otherwise it clears to 0); grad, h, leak, sel per-beat inputs; result = S2 register.
module activation_derivative_lane
    import tpu_act_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s1_en,
    input  logic                    s1_load,
    input  logic                    s2_en,
    input  logic                    s2_load,
    input  logic signed [WIDTH-1:0] grad,
    input  logic signed [WIDTH-1:0] h,
    input  logic signed [WIDTH-1:0] leak,
    input  lane_sel_e               sel,
    output logic signed [WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * WIDTH;

    logic                    s1_neg;
    logic signed [WIDTH-1:0] s1_pass;
    logic signed [PW-1:0]    s1_prod;
    lane_sel_e               s1_sel;
    logic signed [WIDTH-1:0] leak_res;
    logic signed [WIDTH-1:0] sel_res;

    // S1: sign, pass value, raw product, select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_neg  <= 1'b0;
            s1_pass <= '0;
            s1_prod <= '0;
            s1_sel  <= SEL_ZERO;
        end else if (s1_en) begin
            if (s1_load) begin
                s1_neg  <= h[WIDTH-1];
                s1_pass <= grad;
                s1_prod <= PW'(grad) * PW'(leak);
                s1_sel  <= sel;
            end else begin
                s1_neg  <= 1'b0;
                s1_pass <= '0;
                s1_prod <= '0;
                s1_sel  <= SEL_ZERO;
            end
        end
    end

    // Leaky branch value and final select; h == 0 takes the pass path
    always_comb begin
        leak_res = WIDTH'(round_sat(MAX_PROD_W'(s1_prod), WIDTH, FRAC));
        sel_res  = '0;
        case (s1_sel)
            SEL_PASS:  sel_res = s1_pass;
            SEL_RELU:  sel_res = s1_neg ? '0 : s1_pass;
            SEL_LEAKY: sel_res = s1_neg ? leak_res : s1_pass;
            default:   sel_res = '0;
        endcase
    end

    // S2: registered result, cleared when the stage empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (s2_en) begin
            result <= s2_load ? sel_res : '0;
        end
    end

endmodule

// File: rtl/activation_derivative_array.sv
// Multi-lane pipelined activation-derivative unit (ReLU / leaky / identity)
// with valid/ready flow control, per-beat mode/leak/mask and an output beat counter.
// Ports: clk, rst (async, active-high); in_valid/in_ready input handshake;
// in_grad/in_h packed lanes; in_leak, in_mode, in_mask per-beat config;
// out_valid/out_ready output handshake; out_data packed lanes;
// out_count = transferred output beats, wrapping.
module activation_derivative_array
    import tpu_act_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_grad,
    input  logic [LANES*WIDTH-1:0] in_h,
    input  logic [WIDTH-1:0]       in_leak,
    input  logic [1:0]             in_mode,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       out_count
);

    logic      s1_valid;
    logic      s2_valid;
    logic      s1_adv;
    logic      s2_adv;
    act_mode_e mode;

    // Stage advance conditions; in_ready never depends on in_valid
    always_comb begin
        s2_adv = !s2_valid || out_ready;
        s1_adv = s2_adv || !s1_valid;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign mode      = act_mode_e'(in_mode);

    // Stage valids and output beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_count <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_valid && out_ready) begin
                out_count <= out_count + CNT_W'(1);
            end
        end
    end

    // Per-lane datapaths sharing the stage enables
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        lane_sel_e sel;
        assign sel = decode_sel(mode, in_mask[i]);

        activation_derivative_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .s1_en   (s1_adv),
            .s1_load (in_valid),
            .s2_en   (s2_adv),
            .s2_load (s1_valid),
            .grad    (in_grad[i*WIDTH +: WIDTH]),
            .h       (in_h[i*WIDTH +: WIDTH]),
            .leak    (in_leak),
            .sel     (sel),
            .result  (out_data[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: doc/activation_derivative_array.md
# activation_derivative_array

Multi-lane, pipelined activation-derivative unit for the backward pass. It accepts LANES incoming gradients together with the matching forward pre-activations H. Per beat, it applies the derivative of the selected activation (ReLU, leaky ReLU, identity) in signed fixed point, with round-half-up and saturation. It sits between the systolic array's gradient output and the weight-update / next-layer backprop path, and is the parametrised successor of the single-lane leaky-ReLU derivative cell. It adds valid/ready backpressure, a runtime mode, per-lane masking and a beat counter.

## Interface
Parameters:
- LANES, 4, number of parallel lanes (≥1)
- WIDTH, 16, signed data width of gradient, H and leak factor
- FRAC, 8, fractional bits of the Q format (1 ≤ FRAC < WIDTH)
- CNT_W, 32, beat-counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_grad  in  LANES*WIDTH  signed gradients; lane i at [i*WIDTH +: WIDTH]
- in_h  in  LANES*WIDTH  signed forward pre-activations, same packing as in_grad
- in_leak  in  WIDTH  signed leak factor (Q(WIDTH-FRAC).FRAC); shared by all lanes
- in_mode  in  2  0=RELU, 1=LEAKY, 2=IDENTITY, 3=reserved (outputs zero)
- in_mask  in  LANES  1=lane active; 0 forces the lane result to 0
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  LANES*WIDTH  signed results, same packing
- out_count  out  CNT_W  number of output beats transferred since reset; wraps

## Operation
- in_leak, in_mode and in_mask are sampled per accepted beat and travel with the beat. A configuration change therefore never affects beats already in flight.
- Per lane, when mask=1:
  - RELU: result = grad when h ≥ 0, else 0.
  - LEAKY: result = grad when h ≥ 0, else sat(round(grad*leak)).
  - IDENTITY: result = grad.
  - reserved: result = 0.
- When mask=0, the lane result is 0.
- h == 0 counts as non-negative in every mode.
- Arithmetic:
  - Full 2*WIDTH signed product, plus 2^(FRAC-1) for round-half-up (toward +inf), then arithmetic shift right by FRAC.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Pass-through paths are not rounded or saturated.
- Pipeline:
  - S1 registers the lane sign select, pass value, raw product and masked/mode-decoded control.
  - S2 registers the rounded, saturated and selected result.
- out_count increments by 1 on every cycle with out_valid && out_ready, and wraps modulo 2^CNT_W.

## Timing
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Flow control:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when S2 advances || !s1_valid.
  - in_ready = S1 advance condition. This is combinational from out_ready and the stage valids, with no combinational path from in_valid.
- While out_valid && !out_ready, out_data and out_valid hold stable. A beat in S1 holds, and no beat is lost or duplicated.
- A stage that becomes empty clears its data registers to 0. out_data is therefore 0 whenever out_valid = 0.
- Simultaneous accept and emit in the same cycle is allowed (full-rate streaming).
- Reset values: out_valid=0, out_data=0, out_count=0, all stage valids and data 0.
- in_ready is 1 during and immediately after reset release.
- Reset asserted mid-stream discards all in-flight beats. The first post-reset output is the first beat accepted after release.

## Structure
- Shared package tpu_act_pkg holds the mode encoding (act_mode_e: ACT_RELU, ACT_LEAKY, ACT_IDENTITY, ACT_RSVD) and the fixed-point saturate/round helper function. The same helper is reused by forward activation blocks.
- Sub-module activation_derivative_lane (one per lane, generate loop) holds the per-lane S1/S2 datapath, with stage enables driven from the shared control.
- The valid/ready pipeline control and out_count live in the top level.

## Test plan
Values are for WIDTH=16, FRAC=8.
- LEAKY, grad=0x0100, h=0xFFFB, leak=0x0003, mask=all → all lanes 0x0003, exactly 2 cycles after acceptance. With h=0x0000, all lanes → 0x0100.
- Rounding/saturation, LEAKY, h negative, lanes grad = {0x0001, 0xFFFF, 0x7FFF, 0x8000}:
  - grad 0x0001 with leak=0x0080 → 0x0001.
  - grad 0xFFFF with leak=0x0080 → 0x0000.
  - grad 0x7FFF with leak=0x0200 → 0x7FFF.
  - grad 0x8000 with leak=0x0200 → 0x8000.
- Modes and mask:
  - RELU, h negative → 0.
  - IDENTITY, h negative → grad.
  - Mode 3 → 0.
  - mask=4'b0101 → lanes 1 and 3 are 0.
- Backpressure: stream 10 beats with out_ready toggled 1,0,0,1 repeating. Required response: all 10 outputs in order, no loss or duplicates, data stable during stalls, out_count=10, in_ready low only while both stages are full and stalled.
- Per-beat config: alternate LEAKY/RELU and leak 0x0003/0x0100 on back-to-back beats. Each output reflects its own beat's config.
- Reset: assert rst with 2 beats in flight. out_valid and out_data drop to 0 immediately (asynchronous), out_count=0, and no stale beat emerges after release.
